// File: rtl/rsp_s1_prep_phase_cfg_loader.sv
// Loads phase-generator configuration from a valid/ready cfg stream: ENTRY_NUM entry words to ram1,
// then COE_NUM coefficient words to ram0, then publishes the entry select; also serves ram0 readbacks.
module rsp_s1_prep_phase_cfg_loader #(
  parameter int RAM0_ADDR_WIDTH = 11,
  parameter int RAM1_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH  = 64,
  parameter int ENTRY_NUM       = 32,
  parameter int COE_NUM         = 1024,
  parameter int RDBK_LAT        = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_load_start,
  input  logic                         i_abort,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [RAM_DATA_WIDTH-1:0]    i_cfg_data,
  input  logic                         i_cfg_last,
  input  logic [RAM1_ADDR_WIDTH-1:0]   i_entry_sel,
  output logic                         o_phase_ram1_ena,
  output logic                         o_phase_ram1_wena,
  output logic [RAM_DATA_WIDTH/2-1:0]  o_phase_ram1_dina,
  output logic [RAM1_ADDR_WIDTH-1:0]   o_phase_entry_select,
  output logic [RAM0_ADDR_WIDTH-1:0]   o_phase_ram0_addra,
  output logic                         o_phase_ram0_ena,
  output logic                         o_phase_ram0_wena,
  output logic                         o_phase_ram0_bwea,
  output logic [RAM_DATA_WIDTH-1:0]    o_phase_ram0_dina,
  input  logic [RAM_DATA_WIDTH-1:0]    i_phase_ram0_douta,
  input  logic                         i_rdbk_req,
  input  logic [RAM0_ADDR_WIDTH-1:0]   i_rdbk_addr,
  output logic                         o_rdbk_valid,
  output logic [RAM_DATA_WIDTH-1:0]    o_rdbk_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic [2:0]                   o_dbg_state
);

  // cfg stream: a beat is transferred on any edge where i_cfg_valid and o_cfg_ready are both high;
  // the source may hold valid low for any number of cycles, and ready depends only on the state.

  localparam int EW = $clog2(ENTRY_NUM + 1);
  localparam int RW = $clog2(RDBK_LAT + 1);
  localparam logic [EW-1:0]              ENT_LAST = EW'(ENTRY_NUM - 1);
  localparam logic [RAM0_ADDR_WIDTH-1:0] COE_LAST = RAM0_ADDR_WIDTH'(COE_NUM - 1);
  localparam logic [RW-1:0]              LAT_LAST = RW'(RDBK_LAT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ENT  = 3'd1,
    S_COE  = 3'd2,
    S_DONE = 3'd3,
    S_RDBK = 3'd4
  } state_t;

  state_t                       state;
  logic [EW-1:0]                ent_cnt;
  logic [RAM0_ADDR_WIDTH-1:0]   coe_cnt;
  logic [RW-1:0]                rd_cnt;
  logic                         beat;

  assign o_cfg_ready = (state == S_ENT) || (state == S_COE);
  assign beat        = i_cfg_valid && o_cfg_ready;
  assign o_dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      ent_cnt              <= '0;
      coe_cnt              <= '0;
      rd_cnt               <= '0;
      o_phase_ram1_ena     <= 1'b0;
      o_phase_ram1_wena    <= 1'b0;
      o_phase_ram1_dina    <= '0;
      o_phase_entry_select <= '0;
      o_phase_ram0_addra   <= '0;
      o_phase_ram0_ena     <= 1'b0;
      o_phase_ram0_wena    <= 1'b0;
      o_phase_ram0_bwea    <= 1'b0;
      o_phase_ram0_dina    <= '0;
      o_rdbk_valid         <= 1'b0;
      o_rdbk_data          <= '0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      o_err                <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      o_phase_ram1_ena  <= 1'b0;
      o_phase_ram1_wena <= 1'b0;
      o_phase_ram0_ena  <= 1'b0;
      o_phase_ram0_wena <= 1'b0;
      o_phase_ram0_bwea <= 1'b0;
      o_rdbk_valid      <= 1'b0;
      if (i_abort) begin
        state  <= S_IDLE;
        o_busy <= 1'b0;
        o_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (i_load_start) begin
              state   <= S_ENT;
              ent_cnt <= '0;
              coe_cnt <= '0;
              o_busy  <= 1'b1;
              o_done  <= 1'b0;
              o_err   <= 1'b0;
            end else if ((state == S_DONE) && i_rdbk_req) begin
              state              <= S_RDBK;
              rd_cnt             <= '0;
              o_busy             <= 1'b1;
              o_phase_ram0_ena   <= 1'b1;
              o_phase_ram0_addra <= i_rdbk_addr;
            end
          end
          S_ENT: begin
            if (beat) begin
              o_phase_ram1_ena  <= 1'b1;
              o_phase_ram1_wena <= 1'b1;
              o_phase_ram1_dina <= i_cfg_data[RAM_DATA_WIDTH/2-1:0];
              if (i_cfg_last) o_err <= 1'b1;
              if (ent_cnt == ENT_LAST) state <= S_COE;
              else ent_cnt <= ent_cnt + EW'(1);
            end
          end
          S_COE: begin
            if (beat) begin
              o_phase_ram0_ena   <= 1'b1;
              o_phase_ram0_wena  <= 1'b1;
              o_phase_ram0_bwea  <= 1'b1;
              o_phase_ram0_addra <= coe_cnt;
              o_phase_ram0_dina  <= i_cfg_data;
              if (coe_cnt == COE_LAST) begin
                state                <= S_DONE;
                o_busy               <= 1'b0;
                o_done               <= 1'b1;
                o_phase_entry_select <= i_entry_sel;
                if (!i_cfg_last) o_err <= 1'b1;
              end else begin
                if (i_cfg_last) o_err <= 1'b1;
                coe_cnt <= coe_cnt + RAM0_ADDR_WIDTH'(1);
              end
            end
          end
          S_RDBK: begin
            // douta for the strobe issued on entry is valid RDBK_LAT cycles after that strobe.
            if (rd_cnt == LAT_LAST) begin
              state        <= S_DONE;
              o_busy       <= 1'b0;
              o_rdbk_valid <= 1'b1;
              o_rdbk_data  <= i_phase_ram0_douta;
            end else begin
              rd_cnt <= rd_cnt + RW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsp_s1_prep_phase_cfg_loader.sv
// Directed-sequence bench for the phase cfg loader with randomized data/gaps and a queue-based
// reference model of the expected ram1/ram0 write streams, error flag and readback timing.
module tb_rsp_s1_prep_phase_cfg_loader;

  localparam int ENTRY_NUM = 32;
  localparam int COE_NUM   = 1024;
  localparam int TOTAL     = ENTRY_NUM + COE_NUM;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_load_start, i_abort, i_cfg_valid, i_cfg_last, i_rdbk_req;
  logic [63:0] i_cfg_data, i_phase_ram0_douta;
  logic [5:0]  i_entry_sel;
  logic [10:0] i_rdbk_addr;
  logic        o_cfg_ready, o_phase_ram1_ena, o_phase_ram1_wena;
  logic [31:0] o_phase_ram1_dina;
  logic [5:0]  o_phase_entry_select;
  logic [10:0] o_phase_ram0_addra;
  logic        o_phase_ram0_ena, o_phase_ram0_wena, o_phase_ram0_bwea;
  logic [63:0] o_phase_ram0_dina, o_rdbk_data;
  logic        o_rdbk_valid, o_busy, o_done, o_err;
  logic [2:0]  o_dbg_state;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_ent_q[$], obs_ent_q[$];
  logic [74:0] exp_coe_q[$], obs_coe_q[$];

  always #5 clk = ~clk;

  rsp_s1_prep_phase_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .i_load_start(i_load_start), .i_abort(i_abort),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_data(i_cfg_data),
    .i_cfg_last(i_cfg_last), .i_entry_sel(i_entry_sel),
    .o_phase_ram1_ena(o_phase_ram1_ena), .o_phase_ram1_wena(o_phase_ram1_wena),
    .o_phase_ram1_dina(o_phase_ram1_dina), .o_phase_entry_select(o_phase_entry_select),
    .o_phase_ram0_addra(o_phase_ram0_addra), .o_phase_ram0_ena(o_phase_ram0_ena),
    .o_phase_ram0_wena(o_phase_ram0_wena), .o_phase_ram0_bwea(o_phase_ram0_bwea),
    .o_phase_ram0_dina(o_phase_ram0_dina), .i_phase_ram0_douta(i_phase_ram0_douta),
    .i_rdbk_req(i_rdbk_req), .i_rdbk_addr(i_rdbk_addr), .o_rdbk_valid(o_rdbk_valid),
    .o_rdbk_data(o_rdbk_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({o_cfg_ready, o_phase_ram1_ena, o_phase_ram1_wena, o_phase_ram0_ena,
                              o_phase_ram0_wena, o_phase_ram0_bwea, o_rdbk_valid, o_busy, o_done, o_err}), 64'd0);
    check({tag, "_dat"}, o_phase_ram0_dina | o_rdbk_data | 64'(o_phase_ram1_dina) |
                         64'(o_phase_ram0_addra) | 64'(o_phase_entry_select), 64'd0);
  endtask

  // One load: gaps randomizes valid, extra_last marks a wrong beat, drop_last omits the final
  // last flag, abort_at/rst_at interrupt after that many beats, start_at pulses a stray start.
  task automatic do_load(input bit gaps, input int extra_last, input bit drop_last,
                         input int abort_at, input int rst_at, input int start_at,
                         input logic [5:0] sel);
    int idx = 0;
    int cycles = 0;
    int strobe_err = 0;
    int mism = 0;
    bit model_err = 1'b0;
    bit beat, ok, v;
    exp_ent_q.delete(); obs_ent_q.delete(); exp_coe_q.delete(); obs_coe_q.delete();
    @(negedge clk);
    i_load_start = 1'b1;
    i_entry_sel  = sel;
    @(posedge clk); #1;
    i_load_start = 1'b0;
    check("start_busy", 64'(o_busy), 64'd1);
    check("start_ready", 64'(o_cfg_ready), 64'd1);
    check("start_done_err", 64'({o_done, o_err}), 64'd0);
    while (idx < TOTAL && cycles < TOTAL * 4 + 100) begin
      @(negedge clk);
      cycles++;
      if (idx == abort_at) begin
        i_cfg_valid = 1'b0;
        i_abort     = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort_ready", 64'(o_cfg_ready), 64'd0);
        check("abort_busy_done", 64'({o_busy, o_done}), 64'd0);
        check("abort_strobes", 64'({o_phase_ram1_ena, o_phase_ram0_ena}), 64'd0);
        @(posedge clk); #1;
        check("abort_idle_ready", 64'(o_cfg_ready), 64'd0);
        return;
      end
      if (idx == rst_at) begin
        i_cfg_valid = 1'b1;
        rst_n       = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk); #1;
        check_all_zero("rst_held");
        @(negedge clk);
        i_cfg_valid = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_release");
        return;
      end
      v            = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_cfg_valid  = v;
      i_cfg_data   = {$urandom, $urandom};
      i_cfg_last   = (idx == extra_last) || ((idx == TOTAL - 1) && !drop_last);
      i_load_start = (idx == start_at);
      beat         = v && o_cfg_ready;
      if (beat) begin
        if (idx < ENTRY_NUM) exp_ent_q.push_back(i_cfg_data[31:0]);
        else exp_coe_q.push_back({11'(idx - ENTRY_NUM), i_cfg_data});
        if (i_cfg_last != (idx == TOTAL - 1)) model_err = 1'b1;
      end
      @(posedge clk); #1;
      if (o_phase_ram1_ena) obs_ent_q.push_back(o_phase_ram1_dina);
      if (o_phase_ram0_ena && o_phase_ram0_wena) obs_coe_q.push_back({o_phase_ram0_addra, o_phase_ram0_dina});
      if (!beat) ok = !o_phase_ram1_ena && !o_phase_ram0_ena;
      else if (idx < ENTRY_NUM) ok = o_phase_ram1_ena && !o_phase_ram0_ena;
      else ok = o_phase_ram0_ena && !o_phase_ram1_ena;
      ok = ok && (o_phase_ram1_wena == o_phase_ram1_ena) && (o_phase_ram0_wena == o_phase_ram0_ena)
              && (o_phase_ram0_bwea == o_phase_ram0_ena);
      if (!ok) strobe_err++;
      check("err_track", 64'(o_err), 64'(model_err));
      if (beat) idx++;
    end
    i_cfg_valid = 1'b0; i_cfg_last = 1'b0; i_load_start = 1'b0;
    check("load_complete", 64'(idx), 64'(TOTAL));
    check("strobe_timing", 64'(strobe_err), 64'd0);
    check("ent_count", 64'(obs_ent_q.size()), 64'(exp_ent_q.size()));
    check("coe_count", 64'(obs_coe_q.size()), 64'(exp_coe_q.size()));
    foreach (exp_ent_q[i]) if (i >= obs_ent_q.size() || obs_ent_q[i] !== exp_ent_q[i]) mism++;
    foreach (exp_coe_q[i]) if (i >= obs_coe_q.size() || obs_coe_q[i] !== exp_coe_q[i]) mism++;
    check("write_stream", 64'(mism), 64'd0);
    check("done_flags", 64'({o_done, o_busy, o_cfg_ready}), 64'b100);
    check("done_err", 64'(o_err), 64'(model_err));
    check("entry_select", 64'(o_phase_entry_select), 64'(sel));
  endtask

  // Readback: request accepted at edge E0, strobe for one cycle, data captured at E0+4.
  task automatic do_rdbk(input logic [10:0] addr, input logic [63:0] val);
    @(negedge clk);
    i_rdbk_req = 1'b1; i_rdbk_addr = addr; i_phase_ram0_douta = {$urandom, $urandom};
    @(posedge clk); #1;
    check("rdbk_strobe", 64'({o_phase_ram0_ena, o_phase_ram0_wena, o_phase_ram0_bwea}), 64'b100);
    check("rdbk_addr", 64'(o_phase_ram0_addra), 64'(addr));
    check("rdbk_busy", 64'({o_busy, o_rdbk_valid}), 64'b10);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      i_rdbk_addr = 11'($urandom); i_phase_ram0_douta = {$urandom, $urandom};
      @(posedge clk); #1;
      check("rdbk_wait", 64'({o_phase_ram0_ena, o_rdbk_valid}), 64'd0);
    end
    @(negedge clk);
    i_rdbk_req = 1'b0; i_phase_ram0_douta = val;
    @(posedge clk); #1;
    check("rdbk_valid", 64'(o_rdbk_valid), 64'd1);
    check("rdbk_data", o_rdbk_data, val);
    check("rdbk_ret", 64'({o_busy, o_done}), 64'b01);
    @(negedge clk);
    i_phase_ram0_douta = {$urandom, $urandom};
    @(posedge clk); #1;
    check("rdbk_pulse", 64'({o_rdbk_valid, o_phase_ram0_ena}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_load_start = 1'b0; i_abort = 1'b0; i_cfg_valid = 1'b0; i_cfg_last = 1'b0;
    i_cfg_data = '0; i_entry_sel = '0; i_rdbk_req = 1'b0; i_rdbk_addr = '0;
    i_phase_ram0_douta = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    do_load(1'b0, -1, 1'b0, -1, -1, 600, 6'd17);
    do_rdbk(11'd5, 64'hA5A5_0000_1234_5678);
    do_rdbk(11'($urandom_range(0, 1023)), {$urandom, $urandom});
    do_rdbk(11'd1023, {$urandom, $urandom});

    do_load(1'b1, 40, 1'b0, -1, -1, -1, 6'd42);

    @(negedge clk);
    i_load_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #1;
    i_load_start = 1'b0; i_abort = 1'b0;
    check("startabort_ready", 64'({o_cfg_ready, o_busy, o_done}), 64'd0);
    check("startabort_err_kept", 64'(o_err), 64'd1);

    do_load(1'b0, -1, 1'b0, 10, -1, -1, 6'd3);
    do_load(1'b1, -1, 1'b1, -1, -1, -1, 6'd63);
    do_load(1'b0, -1, 1'b0, -1, 500, -1, 6'd9);
    do_load(1'b0, -1, 1'b0, -1, -1, -1, 6'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
